// File: rtl/mining_job_dma_pkg.sv
// mining_pkg: shared FSM state encoding and result-record constants for mining_job_dma.
// Contents: state_t (job sequencer states), status codes written as result word 0,
// RESULT_WORDS (length of the result record in words).
package mining_pkg;
    typedef enum logic [2:0] {
        IDLE,
        RD_GO,
        RD_DATA,
        DISPATCH,
        MINE,
        WR_GO,
        WR_DATA,
        WR_WAIT
    } state_t;
    localparam logic [1:0] ST_EXHAUSTED = 2'd0;
    localparam logic [1:0] ST_FOUND     = 2'd1;
    localparam logic [1:0] ST_ABORTED   = 2'd2;
    localparam int RESULT_WORDS = 3;
endpackage

// File: rtl/mining_job_dma_if.sv
// mining_job_dma_if: Avalon-MM read/write master control and user-FIFO signals.
// master modport: the job sequencer (drives control/go/pop/push).
// slave modport: the read/write master pair (returns done, FIFO head/available, FIFO full).
interface mining_job_dma_if #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32
);
    logic                    read_control_fixed_location;
    logic [ADDRESSWIDTH-1:0] read_control_read_base;
    logic [ADDRESSWIDTH-1:0] read_control_read_length;
    logic                    read_control_go;
    logic                    read_control_done;
    logic                    read_user_read_buffer;
    logic [DATAWIDTH-1:0]    read_user_buffer_output_data;
    logic                    read_user_data_available;
    logic                    write_control_fixed_location;
    logic [ADDRESSWIDTH-1:0] write_control_write_base;
    logic [ADDRESSWIDTH-1:0] write_control_write_length;
    logic                    write_control_go;
    logic                    write_control_done;
    logic                    write_user_write_buffer;
    logic [DATAWIDTH-1:0]    write_user_buffer_data;
    logic                    write_user_buffer_full;

    modport master (
        output read_control_fixed_location, read_control_read_base, read_control_read_length,
               read_control_go, read_user_read_buffer,
               write_control_fixed_location, write_control_write_base, write_control_write_length,
               write_control_go, write_user_write_buffer, write_user_buffer_data,
        input  read_control_done, read_user_buffer_output_data, read_user_data_available,
               write_control_done, write_user_buffer_full
    );

    modport slave (
        input  read_control_fixed_location, read_control_read_base, read_control_read_length,
               read_control_go, read_user_read_buffer,
               write_control_fixed_location, write_control_write_base, write_control_write_length,
               write_control_go, write_user_write_buffer, write_user_buffer_data,
        output read_control_done, read_user_buffer_output_data, read_user_data_available,
               write_control_done, write_user_buffer_full
    );
endinterface

// File: rtl/mining_job_dma_found_arbiter.sv
// found_arbiter: lowest-index priority select of the winning core's solution nonce.
// Ports: found (per-core strobe), nonce (packed per-core nonces) in;
//        any_found (some core reported), win_nonce (nonce of lowest asserted core) out.
module found_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATAWIDTH = 32
) (
    input  logic [NUM_CORES-1:0]           found,
    input  logic [NUM_CORES*DATAWIDTH-1:0] nonce,
    output logic                           any_found,
    output logic [DATAWIDTH-1:0]           win_nonce
);
    assign any_found = |found;

    // Scanning downward lets the lowest asserted index overwrite any higher one.
    always_comb begin
        win_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (found[i]) win_nonce = nonce[i*DATAWIDTH +: DATAWIDTH];
    end
endmodule

// File: rtl/mining_job_dma.sv
// mining_job_dma: fetches a block-header job, fans it out to the hashing cores,
// arbitrates the outcome and writes a 3-word result record {status, nonce, cycles}.
// Ports: clk/reset (async, active-high); job_start/job_base/job_abort in, job_busy/job_done/
// display_data out; bus = read/write master pair; core_* = broadcast header, per-core nonce
// slice base and start pulses out, found/exhausted/nonce from the cores in.
module mining_job_dma
    import mining_pkg::*;
#(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int HDR_WORDS    = 20,
    parameter int NUM_CORES    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           job_start,
    input  logic [ADDRESSWIDTH-1:0]        job_base,
    input  logic                           job_abort,
    output logic                           job_busy,
    output logic                           job_done,
    output logic [31:0]                    display_data,
    mining_job_dma_if.master               bus,
    output logic [HDR_WORDS*DATAWIDTH-1:0] core_header,
    output logic [NUM_CORES*DATAWIDTH-1:0] core_nonce_base,
    output logic [NUM_CORES-1:0]           core_start,
    output logic                           core_abort,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NUM_CORES-1:0]           core_exhausted,
    input  logic [NUM_CORES*DATAWIDTH-1:0] core_nonce
);
    localparam int CW = $clog2(HDR_WORDS + 1);
    localparam int IW = HDR_WORDS > 1 ? $clog2(HDR_WORDS) : 1;
    localparam int SHIFT = DATAWIDTH - $clog2(NUM_CORES);
    localparam logic [CW-1:0] LAST = CW'(HDR_WORDS);
    localparam logic [ADDRESSWIDTH-1:0] HDR_BYTES = ADDRESSWIDTH'(HDR_WORDS * 4);
    localparam logic [ADDRESSWIDTH-1:0] RES_BYTES = ADDRESSWIDTH'(RESULT_WORDS * 4);

    state_t                  state, state_n;
    logic [CW-1:0]           count;
    logic                    rd_done_seen;
    logic [ADDRESSWIDTH-1:0] base;
    logic [DATAWIDTH-1:0]    hdr [HDR_WORDS];
    logic [31:0]             cycles;
    logic [1:0]              status;
    logic [DATAWIDTH-1:0]    nonce;
    logic [1:0]              k;
    logic                    any_found, all_exh, mine_exit;
    logic [DATAWIDTH-1:0]    win_nonce;

    found_arbiter #(.NUM_CORES(NUM_CORES), .DATAWIDTH(DATAWIDTH)) u_arb (
        .found     (core_found),
        .nonce     (core_nonce),
        .any_found (any_found),
        .win_nonce (win_nonce)
    );

    assign all_exh   = &core_exhausted;
    assign mine_exit = state == MINE && (any_found || all_exh || job_abort);
    assign job_busy  = state != IDLE;
    assign bus.read_control_fixed_location  = 1'b0;
    assign bus.write_control_fixed_location = 1'b0;
    assign bus.write_user_buffer_data = k == 2'd0 ? DATAWIDTH'(status) : k == 2'd1 ? nonce : DATAWIDTH'(cycles);

    for (genvar g = 0; g < HDR_WORDS; g++) begin : g_hdr
        assign core_header[g*DATAWIDTH +: DATAWIDTH] = hdr[g];
    end

    // Each core gets the top log2(NUM_CORES) nonce bits fixed to its index.
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_nb
        assign core_nonce_base[g*DATAWIDTH +: DATAWIDTH] =
            (state != IDLE && NUM_CORES > 1) ? DATAWIDTH'(g) << SHIFT : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n                        = state;
        bus.read_control_go            = 1'b0;
        bus.read_control_read_base     = '0;
        bus.read_control_read_length   = '0;
        bus.read_user_read_buffer      = 1'b0;
        bus.write_control_go           = 1'b0;
        bus.write_control_write_base   = '0;
        bus.write_control_write_length = '0;
        bus.write_user_write_buffer    = 1'b0;
        core_start                     = '0;
        core_abort                     = 1'b0;
        case (state)
            IDLE:     state_n = job_start ? RD_GO : IDLE;
            RD_GO: begin
                bus.read_control_go          = 1'b1;
                bus.read_control_read_base   = base;
                bus.read_control_read_length = HDR_BYTES;
                state_n                      = RD_DATA;
            end
            RD_DATA: begin
                bus.read_user_read_buffer = bus.read_user_data_available && count < LAST;
                // The read master may report done before or after the final pop.
                state_n = (count == LAST && (rd_done_seen || bus.read_control_done)) ? DISPATCH : RD_DATA;
            end
            DISPATCH: begin
                core_start = '1;
                state_n    = MINE;
            end
            MINE: begin
                core_abort = mine_exit;
                state_n    = mine_exit ? WR_GO : MINE;
            end
            WR_GO: begin
                bus.write_control_go           = 1'b1;
                bus.write_control_write_base   = base + HDR_BYTES;
                bus.write_control_write_length = RES_BYTES;
                state_n                        = WR_DATA;
            end
            WR_DATA: begin
                bus.write_user_write_buffer = !bus.write_user_buffer_full;
                state_n = (!bus.write_user_buffer_full && k == 2'(RESULT_WORDS - 1)) ? WR_WAIT : WR_DATA;
            end
            WR_WAIT:  state_n = bus.write_control_done ? IDLE : WR_WAIT;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            rd_done_seen <= 1'b0;
            base         <= '0;
            for (int i = 0; i < HDR_WORDS; i++) hdr[i] <= '0;
            cycles       <= '0;
            status       <= ST_EXHAUSTED;
            nonce        <= '0;
            k            <= '0;
            job_done     <= 1'b0;
            display_data <= '0;
        end else begin
            job_done <= state == WR_WAIT && bus.write_control_done;
            if (state == IDLE && job_start) begin
                base         <= job_base;
                count        <= '0;
                rd_done_seen <= 1'b0;
            end
            if (state == RD_DATA && bus.read_control_done) rd_done_seen <= 1'b1;
            if (bus.read_user_read_buffer) begin
                hdr[count[IW-1:0]] <= bus.read_user_buffer_output_data;
                count              <= count + 1'b1;
            end
            if (state == DISPATCH) begin
                cycles <= '0;
                k      <= '0;
            end
            if (state == MINE) cycles <= &cycles ? cycles : cycles + 32'd1;
            if (mine_exit) begin
                status <= any_found ? ST_FOUND : all_exh ? ST_EXHAUSTED : ST_ABORTED;
                nonce  <= any_found ? win_nonce : '0;
            end
            if (bus.write_user_write_buffer) k <= k + 2'd1;
            if (state == WR_WAIT && bus.write_control_done) display_data <= 32'(nonce);
        end
    end
endmodule

// File: tb/tb_mining_job_dma.sv
// tb_mining_job_dma: table-driven job scenarios against a read/write master responder model,
// plus a hand-written reset-during-header-fetch sequence.
module tb_mining_job_dma;
    logic         clk = 1'b0;
    logic         reset;
    logic         job_start, job_abort;
    logic [27:0]  job_base;
    logic         job_busy, job_done;
    logic [31:0]  display_data;
    logic [639:0] core_header;
    logic [127:0] core_nonce_base;
    logic [3:0]   core_start, core_found, core_exhausted;
    logic         core_abort;
    logic [127:0] core_nonce;

    always #5 clk = ~clk;

    mining_job_dma_if #(.ADDRESSWIDTH(28), .DATAWIDTH(32)) avm ();

    mining_job_dma #(.ADDRESSWIDTH(28), .DATAWIDTH(32), .HDR_WORDS(20), .NUM_CORES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .job_start       (job_start),
        .job_base        (job_base),
        .job_abort       (job_abort),
        .job_busy        (job_busy),
        .job_done        (job_done),
        .display_data    (display_data),
        .bus             (avm),
        .core_header     (core_header),
        .core_nonce_base (core_nonce_base),
        .core_start      (core_start),
        .core_abort      (core_abort),
        .core_found      (core_found),
        .core_exhausted  (core_exhausted),
        .core_nonce      (core_nonce)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hw(input logic [27:0] b, input int i);
        return 32'hA500_0000 ^ {4'h0, b} ^ (32'(i) * 32'h0001_0101);
    endfunction

    // Responder state: host memory behind the read master, result sink behind the write master.
    logic        cfg_gap = 1'b0, cfg_bp = 1'b0, cfg_early = 1'b0;
    int          rd_idx = 0, pops = 0, abort_pulses = 0, done_pulses = 0, rd_go_cnt = 0, wr_go_cnt = 0;
    logic        rd_active = 1'b0, rd_done_sent = 1'b0, wr_active = 1'b0, gap_ph = 1'b0;
    logic [27:0] rd_base = '0, rd_len = '0, wr_base = '0, wr_len = '0;
    logic [31:0] wr_q [$];

    initial begin
        logic        s_rgo, s_pop, s_wgo, s_push;
        logic [27:0] s_rbase, s_rlen, s_wbase, s_wlen;
        logic [31:0] s_wdata;
        avm.read_control_done            = 1'b0;
        avm.read_user_data_available     = 1'b0;
        avm.read_user_buffer_output_data = '0;
        avm.write_control_done           = 1'b0;
        avm.write_user_buffer_full       = 1'b0;
        forever begin
            @(negedge clk);
            s_rgo   = avm.read_control_go;
            s_rbase = avm.read_control_read_base;
            s_rlen  = avm.read_control_read_length;
            s_pop   = avm.read_user_read_buffer;
            s_wgo   = avm.write_control_go;
            s_wbase = avm.write_control_write_base;
            s_wlen  = avm.write_control_write_length;
            s_push  = avm.write_user_write_buffer;
            s_wdata = avm.write_user_buffer_data;
            if (core_abort) abort_pulses++;
            if (job_done) done_pulses++;
            if (s_rgo) rd_go_cnt++;
            if (s_wgo) wr_go_cnt++;
            @(posedge clk);
            #1;
            if (reset) begin
                rd_active = 1'b0;
                wr_active = 1'b0;
                rd_idx    = 0;
                wr_q.delete();
            end else begin
                if (s_rgo) begin
                    rd_active    = 1'b1;
                    rd_done_sent = 1'b0;
                    rd_idx       = 0;
                    pops         = 0;
                    rd_base      = s_rbase;
                    rd_len       = s_rlen;
                end
                if (s_pop) begin
                    rd_idx++;
                    pops++;
                end
                if (s_wgo) begin
                    wr_active = 1'b1;
                    wr_base   = s_wbase;
                    wr_len    = s_wlen;
                    wr_q.delete();
                end
                if (s_push) wr_q.push_back(s_wdata);
            end
            gap_ph = !gap_ph;
            avm.read_user_data_available     = rd_active && rd_idx < 20 && (!cfg_gap || gap_ph);
            avm.read_user_buffer_output_data = hw(rd_base, rd_idx);
            avm.read_control_done            = 1'b0;
            if (rd_active && !rd_done_sent && rd_idx >= (cfg_early ? 18 : 20)) begin
                avm.read_control_done = 1'b1;
                rd_done_sent          = 1'b1;
            end
            avm.write_user_buffer_full = cfg_bp && !avm.write_user_buffer_full;
            avm.write_control_done     = 1'b0;
            if (wr_active && wr_q.size() == 3) begin
                avm.write_control_done = 1'b1;
                wr_active              = 1'b0;
            end
        end
    end

    typedef struct {
        logic [27:0] base;
        logic [3:0]  found;
        logic [3:0]  exh;
        logic        abort;
        logic        bp;
        logic        gap;
        logic        early;
        logic        restart;
        int          delay;
        logic [31:0] st;
        logic [31:0] nonce;
        logic [27:0] wbase;
    } vec_t;

    vec_t vt [7];

    task automatic run_job(input vec_t v, input string id);
        int   ab0, dn0, rg0, wg0, hbad;
        logic seen;
        logic [31:0] cyc;
        cfg_gap   = v.gap;
        cfg_bp    = v.bp;
        cfg_early = v.early;
        ab0 = abort_pulses;
        dn0 = done_pulses;
        rg0 = rd_go_cnt;
        wg0 = wr_go_cnt;
        @(posedge clk);
        #1;
        job_base  = v.base;
        job_start = 1'b1;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            seen = core_start === 4'hF;
        end
        chk({id, "_dispatch"}, seen, 1);
        hbad = 0;
        for (int i = 0; i < 20; i++) if (core_header[i*32 +: 32] !== hw(v.base, i)) hbad++;
        chk({id, "_header"}, hbad, 0);
        chk({id, "_nbase_hi"}, core_nonce_base[127:64], 64'hC000_0000_8000_0000);
        chk({id, "_nbase_lo"}, core_nonce_base[63:0], 64'h4000_0000_0000_0000);
        for (int c = 1; c <= v.delay; c++) begin
            @(posedge clk);
            #1;
            job_start = v.restart && c == 2;
            job_base  = job_start ? 28'h999 : v.base;
        end
        job_start      = 1'b0;
        job_base       = v.base;
        core_found     = v.found;
        core_exhausted = v.exh;
        job_abort      = v.abort;
        @(negedge clk);
        chk({id, "_core_abort"}, core_abort, 1);
        @(posedge clk);
        #1;
        core_found = '0;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = job_done === 1'b1;
        end
        chk({id, "_done_seen"}, seen, 1);
        chk({id, "_display"}, display_data, v.nonce);
        chk({id, "_busy_low"}, job_busy, 0);
        @(posedge clk);
        #1;
        core_exhausted = '0;
        job_abort      = 1'b0;
        repeat (3) @(negedge clk);
        chk({id, "_rd_base"}, rd_base, v.base);
        chk({id, "_rd_len"}, rd_len, 80);
        chk({id, "_pops"}, pops, 20);
        chk({id, "_wr_base"}, wr_base, v.wbase);
        chk({id, "_wr_len"}, wr_len, 12);
        chk({id, "_pushes"}, wr_q.size(), 3);
        chk({id, "_w_status"}, wr_q.size() > 0 ? wr_q[0] : 32'hx, v.st);
        chk({id, "_w_nonce"}, wr_q.size() > 1 ? wr_q[1] : 32'hx, v.nonce);
        cyc = wr_q.size() > 2 ? wr_q[2] : 32'hFFFF_FFFF;
        total++;
        if (!(cyc + 1 >= 32'(v.delay) && cyc <= 32'(v.delay + 1))) begin
            bad++;
            $display("FAIL %s_cycles: got %0d want %0d+-1", id, cyc, v.delay);
        end
        chk({id, "_abort_pulses"}, abort_pulses - ab0, 1);
        chk({id, "_done_pulses"}, done_pulses - dn0, 1);
        chk({id, "_rd_go_cnt"}, rd_go_cnt - rg0, 1);
        chk({id, "_wr_go_cnt"}, wr_go_cnt - wg0, 1);
    endtask

    initial begin
        int   wg0;
        logic seen;
        vec_t vr;
        core_nonce     = {32'hC000_0001, 32'h8000_1234, 32'h4000_0007, 32'h0000_0AAA};
        core_found     = '0;
        core_exhausted = '0;
        job_abort      = 1'b0;
        job_start      = 1'b0;
        job_base       = '0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_done", {job_busy, job_done}, 0);
        chk("rst_display", display_data, 0);
        chk("rst_header", |core_header, 0);
        chk("rst_core", {core_start, core_abort, |core_nonce_base}, 0);
        chk("rst_rd_ctl", {avm.read_control_go, avm.read_control_read_base, avm.read_control_read_length,
                           avm.read_user_read_buffer, avm.read_control_fixed_location}, 0);
        chk("rst_wr_ctl", {avm.write_control_go, avm.write_control_write_base, avm.write_control_write_length,
                           avm.write_control_fixed_location}, 0);
        chk("rst_wr_data", {avm.write_user_write_buffer, avm.write_user_buffer_data}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // base, found, exh, abort, bp, gap, early, restart, delay, status, nonce, write base
        vt[0] = '{28'h100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 50, 32'd1, 32'h8000_1234, 28'h150};
        vt[1] = '{28'h100, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 32'd1, 32'h4000_0007, 28'h150};
        vt[2] = '{28'h100, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 32'd2, 32'h0, 28'h150};
        vt[3] = '{28'h300, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'd0, 32'h0, 28'h350};
        vt[4] = '{28'h400, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 32'd2, 32'h0, 28'h450};
        vt[5] = '{28'h500, 4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6, 32'd1, 32'h0000_0AAA, 28'h550};
        vt[6] = '{28'hFFF_FFB0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'd1, 32'hC000_0001, 28'h000_0000};
        for (int i = 0; i < 7; i++) run_job(vt[i], $sformatf("v%0d", i));

        cfg_gap   = 1'b0;
        cfg_bp    = 1'b0;
        cfg_early = 1'b0;
        wg0       = wr_go_cnt;
        @(posedge clk);
        #1;
        job_base  = 28'h200;
        job_start = 1'b1;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(posedge clk);
            #2;
            seen = pops >= 7;
        end
        chk("midrst_reached7", seen, 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", job_busy, 0);
        chk("midrst_pop", avm.read_user_read_buffer, 0);
        chk("midrst_header", |core_header, 0);
        chk("midrst_display", display_data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_no_write", wr_go_cnt - wg0, 0);
        vr = '{28'h200, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 32'd1, 32'h0000_0AAA, 28'h250};
        run_job(vr, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
